// File: rtl/sb_rx_pkg.sv
// Shared sideband packet format: opcodes, field positions, the pattern word
// and the decoder FSM states. The TX encoder imports the same constants.
package sb_rx_pkg;

  localparam logic [4:0]  MSG_NO_DATA   = 5'b10010;
  localparam logic [4:0]  MSG_WITH_DATA = 5'b11011;
  localparam logic [63:0] SB_PATTERN    = 64'hAAAA_AAAA_AAAA_AAAA;

  localparam int OPCODE_LSB  = 0;
  localparam int OPCODE_MSB  = 4;
  localparam int CODE_LSB    = 14;
  localparam int CODE_MSB    = 21;
  localparam int SUBCODE_LSB = 32;
  localparam int SUBCODE_MSB = 39;
  localparam int INFO_LSB    = 40;
  localparam int INFO_MSB    = 55;
  localparam int CP_BIT      = 62;
  localparam int DP_BIT      = 63;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_DATA = 1'b1
  } rx_state_e;

  typedef struct packed {
    logic [7:0]  code;
    logic [7:0]  subcode;
    logic [15:0] info;
    logic        dp;
  } rx_hdr_t;

  // Control parity is good when the XOR over header[62:0] (CP included) is 0.
  function automatic logic ctrl_parity_ok(input logic [63:0] word);
    return ~(^word[CP_BIT:0]);
  endfunction

  function automatic rx_hdr_t extract_hdr(input logic [63:0] word);
    rx_hdr_t h;
    h.code    = word[CODE_MSB:CODE_LSB];
    h.subcode = word[SUBCODE_MSB:SUBCODE_LSB];
    h.info    = word[INFO_MSB:INFO_LSB];
    h.dp      = word[DP_BIT];
    return h;
  endfunction

endpackage

// File: rtl/sb_rx_pattern_detector.sv
// SBINIT pattern hunter: saturating count of consecutive pattern words and
// a sticky lock flag, both cleared whenever the enable is low.
module sb_rx_pattern_detector
  import sb_rx_pkg::*;
#(
  parameter int PATTERN_WORDS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        strobe,
  input  logic [63:0] word,
  output logic        detected
);

  localparam int PW = $clog2(PATTERN_WORDS + 1);
  localparam logic [PW-1:0] TARGET = PW'(PATTERN_WORDS);
  localparam logic [PW-1:0] ONE    = PW'(1);

  logic [PW-1:0] cnt;
  logic [PW-1:0] cnt_nxt;

  // Next match count: saturate on pattern, clear on any other word.
  always_comb begin
    cnt_nxt = cnt;
    if (!en) begin
      cnt_nxt = '0;
    end else if (strobe && (word == SB_PATTERN)) begin
      cnt_nxt = (cnt == TARGET) ? cnt : cnt + ONE;
    end else if (strobe) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt;
    end
  end

  // Count register and sticky flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      detected <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      detected <= en & (detected | (cnt_nxt == TARGET));
    end
  end

endmodule

// File: rtl/sb_rx_packet_decoder.sv
// Sideband RX decoder: pattern lock plus header-only / header-plus-data
// message decode with control/data parity checks and a data-wait timeout.
module sb_rx_packet_decoder
  import sb_rx_pkg::*;
#(
  parameter int DATA_WAIT_TIMEOUT = 255,
  parameter int PATTERN_WORDS     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_de_ser_done,
  input  logic [63:0] i_deser_data,
  input  logic        i_pattern_detect_en,
  output logic        o_pattern_detected,
  output logic        o_msg_valid,
  output logic [7:0]  o_msg_code,
  output logic [7:0]  o_msg_subcode,
  output logic [15:0] o_msg_info,
  output logic        o_has_data,
  output logic [63:0] o_data,
  output logic        o_decode_err,
  output logic        o_busy
);

  localparam int CW = $clog2(DATA_WAIT_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(DATA_WAIT_TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);

  rx_state_e     state;
  rx_state_e     state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  rx_hdr_t       hdr;
  rx_hdr_t       hdr_nxt;
  logic          cp_ok;
  logic          cp_ok_nxt;
  logic          valid_nxt;
  logic          err_nxt;
  logic          with_data;
  rx_hdr_t       fld;
  logic [4:0]    opcode;

  assign opcode = i_deser_data[OPCODE_MSB:OPCODE_LSB];

  sb_rx_pattern_detector #(
    .PATTERN_WORDS (PATTERN_WORDS)
  ) u_pattern (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .en       (i_pattern_detect_en),
    .strobe   (i_de_ser_done),
    .word     (i_deser_data),
    .detected (o_pattern_detected)
  );

  // Decode FSM next-state, timeout and pulse generation.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hdr_nxt   = hdr;
    cp_ok_nxt = cp_ok;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    with_data = 1'b0;
    fld       = extract_hdr(i_deser_data);
    case (state)
      IDLE: begin
        if (i_de_ser_done && !i_pattern_detect_en && (i_deser_data != SB_PATTERN)) begin
          if (opcode == MSG_NO_DATA) begin
            if (ctrl_parity_ok(i_deser_data) && !i_deser_data[DP_BIT]) begin
              valid_nxt = 1'b1;
            end else begin
              err_nxt = 1'b1;
            end
          end else if (opcode == MSG_WITH_DATA) begin
            hdr_nxt   = extract_hdr(i_deser_data);
            cp_ok_nxt = ctrl_parity_ok(i_deser_data);
            cnt_nxt   = TIMEOUT_LOAD;
            state_nxt = WAIT_DATA;
          end else begin
            err_nxt = 1'b1;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT_DATA: begin
        fld = hdr;
        if (i_pattern_detect_en) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (i_de_ser_done) begin
          // A strobe on the expiring cycle still wins over the timeout.
          state_nxt = IDLE;
          cnt_nxt   = '0;
          if (cp_ok && ((^i_deser_data) == hdr.dp)) begin
            valid_nxt = 1'b1;
            with_data = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end else if (cnt <= CNT_ONE) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, header capture and timeout counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      hdr   <= '0;
      cp_ok <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hdr   <= hdr_nxt;
      cp_ok <= cp_ok_nxt;
    end
  end

  // Registered outputs; fields only move on a good message.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_msg_valid   <= 1'b0;
      o_decode_err  <= 1'b0;
      o_busy        <= 1'b0;
      o_msg_code    <= 8'h00;
      o_msg_subcode <= 8'h00;
      o_msg_info    <= 16'h0000;
      o_has_data    <= 1'b0;
      o_data        <= 64'h0;
    end else begin
      o_msg_valid  <= valid_nxt;
      o_decode_err <= err_nxt;
      o_busy       <= (state_nxt == WAIT_DATA);
      if (valid_nxt) begin
        o_msg_code    <= fld.code;
        o_msg_subcode <= fld.subcode;
        o_msg_info    <= fld.info;
        o_has_data    <= with_data;
        o_data        <= with_data ? i_deser_data : 64'h0;
      end
    end
  end

endmodule

// File: tb/tb_sb_rx_packet_decoder.sv
// Directed self-checking bench for sb_rx_packet_decoder.
module tb_sb_rx_packet_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        strobe;
  logic [63:0] wdata;
  logic        pen;
  logic        pdet;
  logic        valid;
  logic [7:0]  code;
  logic [7:0]  subcode;
  logic [15:0] info;
  logic        has_data;
  logic [63:0] data;
  logic        err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] PAT     = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] PAYLOAD = 64'hDEAD_BEEF_0000_00FF;

  sb_rx_packet_decoder dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_de_ser_done       (strobe),
    .i_deser_data        (wdata),
    .i_pattern_detect_en (pen),
    .o_pattern_detected  (pdet),
    .o_msg_valid         (valid),
    .o_msg_code          (code),
    .o_msg_subcode       (subcode),
    .o_msg_info          (info),
    .o_has_data          (has_data),
    .o_data              (data),
    .o_decode_err        (err),
    .o_busy              (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input logic [4:0] op, input logic [7:0] c,
                                     input logic [7:0] s, input logic [15:0] inf,
                                     input logic dp);
    logic [63:0] h;
    h = 64'h0;
    h[4:0]   = op;
    h[21:14] = c;
    h[39:32] = s;
    h[55:40] = inf;
    h[63]    = dp;
    h[62]    = ^h[61:0];
    return h;
  endfunction

  // Strobe one word at a negedge; returns on the next negedge, where the
  // registered response to that word is already visible.
  task automatic send(input logic [63:0] w);
    strobe = 1'b1;
    wdata  = w;
    @(negedge clk);
    strobe = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; strobe = 1'b0; wdata = 64'h0; pen = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({pdet, valid, code, subcode, info, has_data, data, err, busy} !== 100'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {pdet, valid, code, subcode, info, has_data, data, err, busy});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pattern;
    pen = 1'b1;
    @(negedge clk);
    send(PAT);
    checks++;
    if (pdet !== 1'b0) begin errors++; $display("FAIL pattern_early1: got %b required 0", pdet); end
    send(64'h0);
    send(PAT);
    checks++;
    if (pdet !== 1'b0) begin errors++; $display("FAIL pattern_early3: got %b required 0", pdet); end
    send(PAT);
    checks++;
    if (pdet !== 1'b1) begin errors++; $display("FAIL pattern_lock: got %b required 1", pdet); end
    send(mk(5'b10010, 8'h91, 8'h05, 16'h1234, 1'b0));
    checks++;
    if (valid !== 1'b0 || err !== 1'b0 || pdet !== 1'b1) begin
      errors++;
      $display("FAIL pattern_mode_no_decode: got valid=%b err=%b pdet=%b required 0 0 1", valid, err, pdet);
    end
    pen = 1'b0;
    @(negedge clk);
    checks++;
    if (pdet !== 1'b0) begin errors++; $display("FAIL pattern_clear: got %b required 0", pdet); end
  endtask

  task automatic test_with_data;
    send(mk(5'b11011, 8'hA5, 8'h3C, 16'hBEEF, 1'b0));
    checks++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      errors++; $display("FAIL wd_busy1: got busy=%b valid=%b required 1 0", busy, valid);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL wd_busy2: got %b required 1", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL wd_busy3: got %b required 1", busy); end
    send(PAYLOAD);
    checks++;
    if (valid !== 1'b1 || err !== 1'b0 || has_data !== 1'b1 || data !== PAYLOAD || busy !== 1'b0) begin
      errors++;
      $display("FAIL wd_msg: got valid=%b err=%b has=%b data=%h busy=%b required 1 0 1 %h 0",
               valid, err, has_data, data, busy, PAYLOAD);
    end
    checks++;
    if (code !== 8'hA5 || subcode !== 8'h3C || info !== 16'hBEEF) begin
      errors++; $display("FAIL wd_fields: got %h %h %h required a5 3c beef", code, subcode, info);
    end
  endtask

  task automatic test_no_data;
    send(mk(5'b10010, 8'h91, 8'h05, 16'h1234, 1'b0));
    checks++;
    if (valid !== 1'b1 || err !== 1'b0 || has_data !== 1'b0 || data !== 64'h0) begin
      errors++;
      $display("FAIL nd_msg: got valid=%b err=%b has=%b data=%h required 1 0 0 0", valid, err, has_data, data);
    end
    checks++;
    if (code !== 8'h91 || subcode !== 8'h05 || info !== 16'h1234) begin
      errors++; $display("FAIL nd_fields: got %h %h %h required 91 05 1234", code, subcode, info);
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL nd_pulse_width: got %b required 0", valid); end
  endtask

  task automatic test_parity;
    logic [63:0] h;
    h = mk(5'b10010, 8'h77, 8'h66, 16'h5555, 1'b0) ^ (64'h1 << 20);
    send(h);
    checks++;
    if (err !== 1'b1 || valid !== 1'b0 || code !== 8'h91 || subcode !== 8'h05 || info !== 16'h1234) begin
      errors++;
      $display("FAIL cp_fault: got err=%b valid=%b fields=%h %h %h required 1 0 91 05 1234",
               err, valid, code, subcode, info);
    end
    send(mk(5'b11011, 8'h12, 8'h34, 16'h5678, 1'b0));
    send(PAYLOAD ^ 64'h1);
    checks++;
    if (err !== 1'b1 || valid !== 1'b0 || has_data !== 1'b0 || data !== 64'h0 || code !== 8'h91) begin
      errors++;
      $display("FAIL dp_fault: got err=%b valid=%b has=%b data=%h code=%h required 1 0 0 0 91",
               err, valid, has_data, data, code);
    end
    send(mk(5'b10010, 8'h01, 8'h02, 16'h0003, 1'b1));
    checks++;
    if (err !== 1'b1 || valid !== 1'b0) begin
      errors++; $display("FAIL nd_dp_set: got err=%b valid=%b required 1 0", err, valid);
    end
  endtask

  task automatic test_back_to_back;
    strobe = 1'b1;
    wdata  = mk(5'b10010, 8'h11, 8'h22, 16'h3333, 1'b0);
    @(negedge clk);
    wdata  = mk(5'b10010, 8'h44, 8'h55, 16'h6666, 1'b0);
    checks++;
    if (valid !== 1'b1 || code !== 8'h11) begin
      errors++; $display("FAIL b2b_first: got valid=%b code=%h required 1 11", valid, code);
    end
    @(negedge clk);
    strobe = 1'b0;
    checks++;
    if (valid !== 1'b1 || code !== 8'h44 || subcode !== 8'h55 || info !== 16'h6666) begin
      errors++;
      $display("FAIL b2b_second: got valid=%b %h %h %h required 1 44 55 6666", valid, code, subcode, info);
    end
  endtask

  task automatic test_timeout;
    int bad;
    send(mk(5'b11011, 8'h0A, 8'h0B, 16'h0C0D, 1'b0));
    bad = 0;
    for (int i = 1; i <= 255; i++) begin
      if (err !== 1'b0 || busy !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL timeout_wait: got %0d bad cycles required 0", bad); end
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_fire: got err=%b busy=%b required 1 0", err, busy);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL timeout_pulse_width: got %b required 0", err); end
    // Payload arriving on the expiring cycle must be accepted.
    send(mk(5'b11011, 8'hC1, 8'hC2, 16'hC3C4, 1'b0));
    repeat (254) @(negedge clk);
    send(PAYLOAD);
    checks++;
    if (valid !== 1'b1 || err !== 1'b0 || data !== PAYLOAD || code !== 8'hC1) begin
      errors++;
      $display("FAIL timeout_edge_data: got valid=%b err=%b data=%h code=%h required 1 0 %h c1",
               valid, err, data, code, PAYLOAD);
    end
  endtask

  task automatic test_robustness;
    int pulses;
    send(PAT);
    checks++;
    if (valid !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL idle_pattern: got valid=%b err=%b required 0 0", valid, err);
    end
    send(mk(5'b00001, 8'h01, 8'h01, 16'h0001, 1'b0));
    checks++;
    if (err !== 1'b1 || valid !== 1'b0) begin
      errors++; $display("FAIL bad_opcode: got err=%b valid=%b required 1 0", err, valid);
    end
    send(mk(5'b11011, 8'h99, 8'h88, 16'h7777, 1'b0));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pdet, valid, code, subcode, info, has_data, data, err, busy} !== 100'h0) begin
      errors++;
      $display("FAIL reset_mid_msg: got %h required 0",
               {pdet, valid, code, subcode, info, has_data, data, err, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL post_reset_quiet: got %0d active cycles required 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_with_data();
    test_no_data();
    test_parity();
    test_back_to_back();
    test_timeout();
    test_robustness();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
